// File: rtl/scroll_pkg.sv
// Shared types and default constants for the parallax scroller.
package scroll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } scroll_state_t;

    localparam int DEF_LAYERS      = 3;
    localparam int DEF_X_W         = 16;
    localparam int DEF_WRAP        = 600;
    localparam int DEF_INIT_SPEED  = 2;
    localparam int DEF_MAX_SPEED   = 8;
    localparam int DEF_ACCEL_TICKS = 500;
    localparam int DEF_SPEED_W     = 4;

    function automatic int sat_inc(input int value, input int limit);
        return (value >= limit) ? limit : value + 1;
    endfunction

endpackage

// File: rtl/scroll_layer.sv
// One scroll layer: position register with modulo-WRAP step and a one-cycle wrap pulse.
module scroll_layer #(
    parameter int X_W     = 16,
    parameter int SPEED_W = 4,
    parameter int WRAP    = 600
) (
    input  logic               clk_100Hz,
    input  logic               rst,
    input  logic               clear,
    input  logic               hold,
    input  logic               step_en,
    input  logic [SPEED_W-1:0] speed,
    output logic [X_W-1:0]     pos,
    output logic               wrap_pulse
);

    localparam logic [X_W:0] WRAP_V = (X_W+1)'(WRAP);

    logic [X_W:0] sum;
    logic [X_W:0] diff;

    // One extra bit so WRAP == 2^X_W and the carry out of x + speed are both representable.
    assign sum  = {1'b0, pos} + (X_W+1)'(speed);
    assign diff = sum - WRAP_V;

    always_ff @(posedge clk_100Hz) begin
        if (rst || clear) begin
            pos        <= '0;
            wrap_pulse <= 1'b0;
        end else if (step_en && !hold) begin
            if (sum >= WRAP_V) begin
                pos        <= diff[X_W-1:0];
                wrap_pulse <= 1'b1;
            end else begin
                pos        <= sum[X_W-1:0];
                wrap_pulse <= 1'b0;
            end
        end else begin
            wrap_pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/parallax_scroll.sv
// Multi-layer scroll-position generator with run/halt/restart control.
// Build option SCROLL_ACCEL_EN enables the play-time speed ramp; otherwise speed stays at INIT_SPEED.
module parallax_scroll
    import scroll_pkg::*;
#(
    parameter int LAYERS      = DEF_LAYERS,
    parameter int X_W         = DEF_X_W,
    parameter int WRAP        = DEF_WRAP,
    parameter int INIT_SPEED  = DEF_INIT_SPEED,
    parameter int MAX_SPEED   = DEF_MAX_SPEED,
    parameter int ACCEL_TICKS = DEF_ACCEL_TICKS,
    parameter int SPEED_W     = DEF_SPEED_W
) (
    input  logic                  clk_100Hz,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  crash,
    input  logic                  restart,
    output logic [LAYERS*X_W-1:0] layer_x,
    output logic [SPEED_W-1:0]    speed,
    output logic [LAYERS-1:0]     wrap_pulse,
    output logic                  running
);

    localparam logic [SPEED_W-1:0] SPEED_RST =
        SPEED_W'((INIT_SPEED > MAX_SPEED) ? MAX_SPEED : INIT_SPEED);

    scroll_state_t       state;
    logic [LAYERS-1:0]   cnt;
    logic [SPEED_W-1:0]  speed_q;
    logic                advance;
    logic                hold;

    // restart and crash both pre-empt a step in the cycle they are sampled.
    assign advance = (state == ST_RUN) && !restart;
    assign hold    = crash || (state == ST_HALT);

    always_ff @(posedge clk_100Hz) begin
        if (rst || restart) begin
            state   <= ST_IDLE;
            running <= 1'b0;
            cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (crash) begin
                        state   <= ST_HALT;
                        running <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HALT: begin
                    running <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    cnt     <= '0;
                end
            endcase
        end
    end

`ifdef SCROLL_ACCEL_EN
    localparam int ACC_W = (ACCEL_TICKS > 2) ? $clog2(ACCEL_TICKS) : 1;
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(ACCEL_TICKS - 1);

    logic [ACC_W-1:0] acc;

    always_ff @(posedge clk_100Hz) begin
        if (rst || restart || state == ST_IDLE) begin
            acc     <= '0;
            speed_q <= SPEED_RST;
        end else if (advance && !crash) begin
            if (acc == ACC_LAST) begin
                acc     <= '0;
                speed_q <= SPEED_W'(sat_inc(int'(speed_q), MAX_SPEED));
            end else begin
                acc <= acc + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk_100Hz) begin
        if (rst || restart) begin
            speed_q <= SPEED_RST;
        end
    end
`endif

    assign speed = speed_q;

    // Layer i steps once every 2^i run cycles, on the cycles where the low i bits of cnt are zero.
    for (genvar i = 0; i < LAYERS; i++) begin : g_layer
        localparam logic [LAYERS-1:0] PHASE_MASK = LAYERS'((1 << i) - 1);

        logic step_en;

        assign step_en = advance && ((cnt & PHASE_MASK) == '0);

        scroll_layer #(
            .X_W     (X_W),
            .SPEED_W (SPEED_W),
            .WRAP    (WRAP)
        ) u_layer (
            .clk_100Hz  (clk_100Hz),
            .rst        (rst),
            .clear      (restart),
            .hold       (hold),
            .step_en    (step_en),
            .speed      (speed_q),
            .pos        (layer_x[i*X_W +: X_W]),
            .wrap_pulse (wrap_pulse[i])
        );
    end

endmodule
